// File: rtl/playfield_sequencer.sv
// playfield_sequencer
// Game-phase controller for the settled-block playfield. It steps the board
// datapath through spawn, gravity, lock, line-clear scan/shift and scoring,
// and owns the gravity timer, clear counter, score and game-over state.
//
// Optional feature macro: PLAYFIELD_SOFT_DROP_EN (adds the soft_drop input,
// forced gravity while it is held, and a one-point bonus for a soft-dropped lock).
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   ce             game tick enable (gravity timer only)
//   start          begin a new game (IDLE / OVER only)
//   collide        piece cannot move down one row (from board)
//   top_blocked    spawn area occupied
//   row_full       row row_idx is full (from board)
//   soft_drop      (PLAYFIELD_SOFT_DROP_EN only) accelerate gravity
//   spawn, step_down, lock, shift_row   one-cycle command strobes
//   row_idx        row under test / being shifted
//   score          running score, saturating
//   game_over      high in OVER
//   busy           high in LOCK, SCAN, SHIFT, SCORE
module playfield_sequencer #(
  parameter int unsigned ROWS       = 20,
  parameter int unsigned DROP_TICKS = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        start,
  input  logic        collide,
  input  logic        top_blocked,
  input  logic        row_full,
`ifdef PLAYFIELD_SOFT_DROP_EN
  input  logic        soft_drop,
`endif
  output logic        spawn,
  output logic        step_down,
  output logic        lock,
  output logic        shift_row,
  output logic [4:0]  row_idx,
  output logic [15:0] score,
  output logic        game_over,
  output logic        busy
);

  localparam int unsigned CntW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DROP_TICKS - 1);
  localparam logic [4:0] RowLast = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StFall,
    StLock,
    StScan,
    StShift,
    StScore,
    StOver
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] grav_q, grav_d;
  logic [2:0]      clr_q, clr_d;
  logic [4:0]      row_d;
  logic [15:0]     score_d;
  logic            step_d;
  logic            soft_q, soft_d;
  logic            soft_now;
  logic            grav_hit;
  logic [3:0]      points;
  logic [16:0]     sum;

`ifdef PLAYFIELD_SOFT_DROP_EN
  assign soft_now = soft_drop;
`else
  assign soft_now = 1'b0;
`endif

  // Soft drop turns every tick into a gravity event.
  assign grav_hit = ce && (soft_now || (grav_q == CntLast));

  always_comb begin
    unique case (clr_q)
      3'd0:    points = 4'd0;
      3'd1:    points = 4'd1;
      3'd2:    points = 4'd3;
      3'd3:    points = 4'd5;
      default: points = 4'd8;
    endcase
  end

  assign sum = {1'b0, score} + 17'(points) + 17'(soft_q);

  always_comb begin
    state_d = state_q;
    grav_d  = grav_q;
    clr_d   = clr_q;
    row_d   = row_idx;
    score_d = score;
    step_d  = 1'b0;
    soft_d  = soft_q;
    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          score_d = '0;
          state_d = StSpawn;
        end
      end
      StSpawn: begin
        soft_d = 1'b0;
        if (top_blocked) begin
          state_d = StOver;
        end else begin
          grav_d  = '0;
          state_d = StFall;
        end
      end
      StFall: begin
        if (ce) begin
          if (grav_hit) begin
            grav_d = '0;
            if (soft_now) soft_d = 1'b1;
            if (collide) state_d = StLock;
            else         step_d  = 1'b1;
          end else begin
            grav_d = grav_q + 1'b1;
          end
        end
      end
      StLock: begin
        row_d   = RowLast;
        clr_d   = '0;
        state_d = StScan;
      end
      StScan: begin
        if (row_full) begin
          // Hold at 7: anything from 4 up scores the same.
          if (clr_q != 3'd7) clr_d = clr_q + 3'd1;
          state_d = StShift;
        end else if (row_idx == 5'd0) begin
          state_d = StScore;
        end else begin
          row_d = row_idx - 5'd1;
        end
      end
      StShift: begin
        state_d = StScan;
      end
      StScore: begin
        score_d = sum[16] ? 16'hFFFF : sum[15:0];
        state_d = StSpawn;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grav_q    <= '0;
      clr_q     <= '0;
      soft_q    <= 1'b0;
      row_idx   <= '0;
      score     <= '0;
      spawn     <= 1'b0;
      step_down <= 1'b0;
      lock      <= 1'b0;
      shift_row <= 1'b0;
      game_over <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grav_q    <= grav_d;
      clr_q     <= clr_d;
      soft_q    <= soft_d;
      row_idx   <= row_d;
      score     <= score_d;
      spawn     <= (state_d == StSpawn);
      step_down <= step_d;
      lock      <= (state_d == StLock);
      shift_row <= (state_d == StShift);
      game_over <= (state_d == StOver);
      busy      <= (state_d == StLock) || (state_d == StScan) ||
                   (state_d == StShift) || (state_d == StScore);
    end
  end

endmodule
